// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Payout side of the coin interface. Accepts a refund amount
//               and drives a coin hopper one coin per four-phase req/ack
//               handshake until the whole amount has been paid out.
//               Coin codes: 2'b01 = 1 unit, 2'b10 = 2 units, 2'b00 = none.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   refund_valid/   : refund request handshake; refund_amount is sampled
//   refund_ready/     on the accepting edge (ready only in IDLE)
//   refund_amount
//   two_empty       : 2-unit tube empty, forces 1-unit coins at next issue
//   hopper_req/     : four-phase dispense handshake with the hopper;
//   hopper_ack/       hopper_coin is valid only while hopper_req is high
//   hopper_coin
//   refund_left     : units still owed
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse when the payout completes
//   fault/          : hopper handshake timed out; held until fault_clear
//   fault_clear
// ============================================================================
module change_dispenser #(
    parameter int AMT_W          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refund_valid,
    input  logic [AMT_W-1:0] refund_amount,
    output logic             refund_ready,
    input  logic             two_empty,
    output logic             hopper_req,
    output logic [1:0]       hopper_coin,
    input  logic             hopper_ack,
    output logic [AMT_W-1:0] refund_left,
    output logic             busy,
    output logic             done,
    output logic             fault,
    input  logic             fault_clear
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AMT_W-1:0] c_two      = AMT_W'(2);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   refund_left_q, refund_left_d;
    logic [1:0]         coin_q, coin_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    always_comb begin
        state_d       = state_q;
        refund_left_d = refund_left_q;
        coin_d        = coin_q;
        timer_d       = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (refund_valid) begin
                    refund_left_d = refund_amount;
                    state_d       = (refund_amount == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A 2-unit coin is chosen only when it cannot overpay.
                coin_d  = ((refund_left_q >= c_two) && !two_empty) ? 2'b10 : 2'b01;
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // Ack takes priority over a coincident timeout.
                if (hopper_ack) begin
                    // The coin code equals its value in units.
                    refund_left_d = refund_left_q - AMT_W'(coin_q);
                    timer_d       = '0;
                    state_d       = ST_RELEASE;
                end else if (timer_q == c_tmr_last) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!hopper_ack) begin
                    timer_d = '0;
                    state_d = (refund_left_q == '0) ? ST_DONE : ST_ISSUE;
                end else if (timer_q == c_tmr_last) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                // refund_left stays frozen at the amount still owed.
                if (fault_clear) begin
                    refund_left_d = '0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            refund_left_q <= '0;
            coin_q        <= 2'b00;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            refund_left_q <= refund_left_d;
            coin_q        <= coin_d;
            timer_q       <= timer_d;
        end
    end

    // Moore-decoded outputs straight from registered state.
    assign refund_ready = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign hopper_req   = (state_q == ST_WAIT_ACK);
    assign hopper_coin  = (state_q == ST_WAIT_ACK) ? coin_q : 2'b00;
    assign done         = (state_q == ST_DONE);
    assign fault        = (state_q == ST_FAULT);
    assign refund_left  = refund_left_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispenser
// Description : Directed self-checking bench for change_dispenser with a
//               behavioural hopper that acks 3 cycles after each request
//               and drops ack once the request falls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    localparam int AMT_W = 4;
    localparam int TO    = 16;

    logic             clk;
    logic             rst;
    logic             refund_valid;
    logic [AMT_W-1:0] refund_amount;
    logic             refund_ready;
    logic             two_empty;
    logic             hopper_req;
    logic [1:0]       hopper_coin;
    logic             hopper_ack;
    logic [AMT_W-1:0] refund_left;
    logic             busy;
    logic             done;
    logic             fault;
    logic             fault_clear;

    int errors = 0;
    int checks = 0;

    int  coins[$];
    int  lefts[$];
    bit  hop_stall;
    int  hcnt;

    change_dispenser #(
        .AMT_W          (AMT_W),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount),
        .refund_ready  (refund_ready),
        .two_empty     (two_empty),
        .hopper_req    (hopper_req),
        .hopper_coin   (hopper_coin),
        .hopper_ack    (hopper_ack),
        .refund_left   (refund_left),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .fault_clear   (fault_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
        end
    endtask

    // Hopper model: ack on the third sampled cycle of req, release when req drops.
    initial begin
        hopper_ack = 1'b0;
        hcnt       = 0;
        forever begin
            tick();
            if (hopper_req === 1'b1 && hopper_ack === 1'b0) begin
                if (!hop_stall) begin
                    hcnt++;
                    if (hcnt == 3) begin
                        hopper_ack = 1'b1;
                        coins.push_back(int'(hopper_coin));
                        hcnt = 0;
                    end
                end
            end else if (hopper_req === 1'b0) begin
                hopper_ack = 1'b0;
                hcnt       = 0;
            end
        end
    end

    // Accept a refund and run it to completion, logging refund_left values.
    task automatic run_payout(input string tag, input int amt, input bit te, input bit spam);
        int dones;
        coins.delete();
        lefts.delete();
        two_empty     = te;
        refund_amount = AMT_W'(amt);
        refund_valid  = 1'b1;
        tick();
        refund_valid = 1'b0;
        check({tag, "_busy_after_accept"}, busy, 1);
        check({tag, "_req_in_issue"}, hopper_req, 0);
        lefts.push_back(int'(refund_left));
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            if (spam) begin
                refund_valid  = (i >= 2 && i < 6);
                refund_amount = 4'd7;
            end
            tick();
            if (i == 0) check({tag, "_req_rise"}, hopper_req, 1);
            if (int'(refund_left) != lefts[$]) lefts.push_back(int'(refund_left));
            if (done === 1'b1) begin
                dones++;
                break;
            end
        end
        refund_valid = 1'b0;
        check({tag, "_done_seen"}, dones, 1);
        tick();
        check({tag, "_done_single"}, done, 0);
        check({tag, "_ready_after"}, refund_ready, 1);
    endtask

    initial begin
        int e_c[$];
        int e_l[$];
        int cnt;
        int rises;
        logic prev_req;

        rst           = 1'b1;
        refund_valid  = 1'b0;
        refund_amount = '0;
        two_empty     = 1'b0;
        fault_clear   = 1'b0;
        hop_stall     = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_ready", refund_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_req", hopper_req, 0);
        check("rst_coin", hopper_coin, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_left", refund_left, 0);

        // Amount 5 with both tubes available
        run_payout("a5", 5, 1'b0, 1'b0);
        e_c = '{2, 2, 1};
        e_l = '{5, 3, 1, 0};
        check_seq("a5_coins", coins, e_c);
        check_seq("a5_left", lefts, e_l);

        // Amount 3 with 2-unit tube empty
        run_payout("a3", 3, 1'b1, 1'b0);
        e_c = '{1, 1, 1};
        e_l = '{3, 2, 1, 0};
        check_seq("a3_coins", coins, e_c);
        check_seq("a3_left", lefts, e_l);
        two_empty = 1'b0;

        // Amount 0: immediate done, no hopper activity
        refund_amount = '0;
        refund_valid  = 1'b1;
        tick();
        refund_valid = 1'b0;
        check("a0_done", done, 1);
        check("a0_busy", busy, 1);
        check("a0_req", hopper_req, 0);
        tick();
        check("a0_done_drop", done, 0);
        check("a0_busy_drop", busy, 0);
        check("a0_ready", refund_ready, 1);
        check("a0_req2", hopper_req, 0);

        // Amount 4 with a hopper that never acks: timeout to FAULT
        hop_stall     = 1'b1;
        refund_amount = 4'd4;
        refund_valid  = 1'b1;
        tick();
        refund_valid = 1'b0;
        tick();
        check("to_req", hopper_req, 1);
        check("to_coin", hopper_coin, 2);
        cnt = 0;
        while (hopper_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("to_req_cycles", cnt, TO);
        check("to_fault", fault, 1);
        check("to_req_low", hopper_req, 0);
        check("to_busy", busy, 1);
        check("to_left", refund_left, 4);
        tick();
        check("to_fault_held", fault, 1);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("fc_ready", refund_ready, 1);
        check("fc_left", refund_left, 0);
        check("fc_fault", fault, 0);
        hop_stall = 1'b0;

        // Amount 6, reset during the second WAIT_ACK
        refund_amount = 4'd6;
        refund_valid  = 1'b1;
        tick();
        refund_valid = 1'b0;
        rises    = 0;
        prev_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (hopper_req === 1'b1 && prev_req === 1'b0) rises++;
            prev_req = hopper_req;
            if (rises == 2) break;
        end
        check("r6_second_req", rises, 2);
        check("r6_left_mid", refund_left, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r6_req", hopper_req, 0);
        check("r6_left", refund_left, 0);
        check("r6_ready", refund_ready, 1);
        run_payout("r2", 2, 1'b0, 1'b0);
        e_c = '{2};
        e_l = '{2, 0};
        check_seq("r2_coins", coins, e_c);
        check_seq("r2_left", lefts, e_l);

        // refund_valid pulsed while busy must be ignored
        run_payout("sp", 2, 1'b0, 1'b1);
        e_c = '{2};
        e_l = '{2, 0};
        check_seq("sp_coins", coins, e_c);
        check_seq("sp_left", lefts, e_l);
        tick();
        check("sp_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
